multicycle_alu: RTL and testbench
=================================

# multicycle_alu

Parametrised, registered successor to the datapath's combinational ALU. It adds a valid/ready handshake on both sides, signed and unsigned compare, both shift directions, and iterative multiply, divide and remainder operations that take WIDTH cycles. It sits between the register-read stage and writeback of the multicycle datapath, and the controller stalls on `in_ready`/`out_valid`.

## Interface
- `WIDTH`, 32: operand/result width; must be a power of two ≥ 8.
- `SHW`, $clog2(WIDTH): shift-amount width (derived; do not override).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  operands and op are presented.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `a`, `b`  in  WIDTH  operands.
- `op`  in  4  operation code.
- `out_valid`  out  1  result is held and valid.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  WIDTH  registered result.
- `zero`  out  1  `out_valid && result == 0`.

## Operation
- Op codes:
  - 0000 add; 0001 sub; 0010 and; 0011 or; 0100 xor.
  - 0101 slt (signed); 0110 sll by `b[SHW-1:0]`; 0111 srl (logical) by `b[SHW-1:0]`; 1011 sltu.
  - 1000 mul (low WIDTH bits of the unsigned product).
  - 1001 divu (quotient); 1010 remu (remainder).
  - 11xx: illegal; result = 0, single-cycle.
- Wrap-around: add, sub and mul are modulo 2^WIDTH. No overflow or carry flags.
- Divide by zero: quotient = all ones, remainder = `a`. Still takes the full WIDTH cycles.
- slt/sltu return 1 or 0, zero-extended to WIDTH.
- FSM states and transitions:
  - IDLE: on accept (`in_valid && in_ready`), single-cycle ops register the result and go to DONE. Ops 1000–1010 latch `a`, `b`, `op`, clear the accumulator, load the counter with WIDTH-1, and go to CALC.
  - CALC: one shift-add step (mul) or one restoring-division step (div/rem) per cycle. At counter == 0, write the result and go to DONE; otherwise decrement the counter.
  - DONE: `out_valid` = 1, with `result` stable. On `out_ready`, go to IDLE. Hold indefinitely while `out_ready` = 0.
- Inputs are ignored outside IDLE; `a`, `b` and `op` may change freely during CALC and DONE.
- Reset (in any state, including mid-CALC): go to IDLE and abort any in-flight operation. `in_ready` = 1 the cycle after reset deasserts. `out_valid` = 0, `result` = 0, `zero` = 0.

## Timing
- Accept edge = T.
- Single-cycle ops: `out_valid` high in cycle T+1.
- mul/divu/remu: `out_valid` high in cycle T+WIDTH+1 (33 cycles at WIDTH=32).
- `in_ready` is low from T+1 until the cycle after the `out_ready` handshake edge. Minimum issue interval is 2 cycles.
- `out_valid` and `out_ready` both high at edge E: the result is consumed and `in_ready` = 1 in cycle E+1. A new op cannot be accepted at edge E itself.
- All outputs are registered except `zero` and `in_ready`, which are decoded combinationally from registered state and `result`.

## Structure
- Package `alu_pkg`: op-code localparams (`OP_ADD` … `OP_REMU`) and the FSM state encoding (IDLE, CALC, DONE).
- Sub-module `alu_core`: purely combinational, WIDTH-parametrised, implementing ops 0000–0111 and 1011.
- Top level holds the FSM, the counter, the mul/div iteration registers and the output register.

## Test plan
- Reset: hold `rst` 3 cycles mid-CALC of a mul. Then `in_ready`=1, `out_valid`=0, `result`=0, and no stale result ever appears.
- Single-cycle ops, each with `out_valid` at T+1:
  - add 0xFFFFFFFF+1 → 0, `zero`=1.
  - sub 5-7 → 0xFFFFFFFE.
  - slt 0xFFFFFFFF,1 → 1; sltu with the same operands → 0.
  - sll 1 by 35 → 8.
- mul 0x10000 × 0x10001 → 0x00010000 (wrapped), with `out_valid` exactly at T+33.
- divu 100/7 → 14; remu 100/7 → 2; divu 9/0 → 0xFFFFFFFF; remu 9/0 → 9.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid`. `result` stays stable, `in_ready`=0, and an input toggling meanwhile is not captured.
- Back-to-back: add, then sub, then mul with `out_ready`=1 throughout. Accepts occur every 2 cycles for single ops, and results emerge in issue order.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op-code map and FSM encoding for the multicycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  function automatic logic is_multi(input logic [3:0] o);
    return (o == OP_MUL) || (o == OP_DIVU) || (o == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU ops; anything not handled here (incl. 11xx) yields 0.
module alu_core import alu_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SLT:  y = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: y = {{(WIDTH-1){1'b0}}, a < b};
      OP_SLL:  y = a << b[SHW-1:0];
      OP_SRL:  y = a >> b[SHW-1:0];
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_alu.sv
// Registered ALU with valid/ready handshake; mul/divu/remu iterate one bit per cycle.
module multicycle_alu import alu_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  state_t           state, state_n;
  logic [SHW-1:0]   cnt, cnt_n;
  logic [3:0]       op_q, op_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [WIDTH-1:0] x, x_n;
  logic [WIDTH-1:0] y, y_n;
  logic [WIDTH-1:0] res_n;
  logic             ov_n;
  logic [WIDTH-1:0] core_y;

  alu_core #(.WIDTH(WIDTH), .SHW(SHW)) u_core (
    .a  (a),
    .b  (b),
    .op (op),
    .y  (core_y)
  );

  // mul: acc = product, x = shifted multiplicand, y = shifted multiplier.
  // div: acc = partial remainder, x = dividend shifting into quotient, y = divisor.
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH:0]   rsh;
  logic             sub_ok;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_quo;

  assign mul_acc = y[0] ? acc + x : acc;
  assign rsh     = {acc, x[WIDTH-1]};
  assign sub_ok  = rsh >= {1'b0, y};
  assign div_rem = sub_ok ? rsh[WIDTH-1:0] - y : rsh[WIDTH-1:0];
  assign div_quo = {x[WIDTH-2:0], sub_ok};

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_n    = op_q;
    acc_n   = acc;
    x_n     = x;
    y_n     = y;
    res_n   = result;
    ov_n    = out_valid;
    case (state)
      S_IDLE: if (in_valid) begin
        if (is_multi(op)) begin
          op_n    = op;
          x_n     = a;
          y_n     = b;
          acc_n   = '0;
          cnt_n   = SHW'(WIDTH-1);
          state_n = S_CALC;
        end else begin
          res_n   = core_y;
          ov_n    = 1'b1;
          state_n = S_DONE;
        end
      end
      S_CALC: begin
        if (op_q == OP_MUL) begin
          acc_n = mul_acc;
          x_n   = x << 1;
          y_n   = y >> 1;
        end else begin
          acc_n = div_rem;
          x_n   = div_quo;
        end
        if (cnt == '0) begin
          res_n   = (op_q == OP_MUL)  ? mul_acc :
                    (op_q == OP_DIVU) ? div_quo : div_rem;
          ov_n    = 1'b1;
          state_n = S_DONE;
        end else begin
          cnt_n = cnt - SHW'(1);
        end
      end
      S_DONE: if (out_ready) begin
        ov_n    = 1'b0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      op_q      <= OP_ADD;
      acc       <= '0;
      x         <= '0;
      y         <= '0;
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      cnt       <= cnt_n;
      op_q      <= op_n;
      acc       <= acc_n;
      x         <= x_n;
      y         <= y_n;
      result    <= res_n;
      out_valid <= ov_n;
    end
  end

  assign in_ready = (state == S_IDLE);
  assign zero     = out_valid && (result == '0);

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench: issue() queues hand-computed results, the monitor pops on each new out_valid.
module tb_multicycle_alu;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   op = '0;
  logic         in_ready, out_valid, zero;
  logic [W-1:0] result;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
    int           acc;
    string        name;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   last_acc = 0;
  logic ov_d = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: one comparison set per rising out_valid.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && out_valid && !ov_d) begin
      if (sbq.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk({e.name, "_result"}, result, e.res);
        chk({e.name, "_zero"}, zero, e.res == '0);
        chk({e.name, "_latency"}, cyc - e.acc, e.lat);
        chk({e.name, "_in_ready_low"}, in_ready, 0);
      end
    end
    ov_d = out_valid;
  end

  task automatic issue(input string name, input logic [3:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] yv, input logic [W-1:0] e, input int lat);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk({name, "_accept_timeout"}, 0, 1);
    op = o; a = x; b = yv; in_valid = 1'b1;
    last_acc = cyc;
    sbq.push_back('{e, lat, cyc, name});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sbq.size() != 0 || !in_ready) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sbq.size() != 0 || !in_ready) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    int a1, a2, a3, t;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    // Single-cycle ops
    issue("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1);
    issue("sub",      OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1);
    issue("slt",      OP_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1, 1);
    issue("sltu",     OP_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 1);
    issue("sll",      OP_SLL, 32'h1, 32'd35, 32'h8, 1);
    issue("srl",      OP_SRL, 32'h8000_0000, 32'd31, 32'h1, 1);
    issue("and",      OP_AND, 32'hF0F0, 32'hFF00, 32'hF000, 1);
    issue("or",       OP_OR,  32'hF0F0, 32'hFF00, 32'hFFF0, 1);
    issue("xor",      OP_XOR, 32'hF0F0, 32'hFF00, 32'h0FF0, 1);
    issue("ill_1100", 4'b1100, 32'd5, 32'd3, 32'h0, 1);
    issue("ill_1111", 4'b1111, 32'd5, 32'd3, 32'h0, 1);

    // Iterative ops
    issue("mul_wrap", OP_MUL, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, W + 1);
    issue("mul_ones", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, W + 1);
    issue("divu",     OP_DIVU, 32'd100, 32'd7, 32'd14, W + 1);
    issue("remu",     OP_REMU, 32'd100, 32'd7, 32'd2, W + 1);
    issue("divu_z",   OP_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, W + 1);
    issue("remu_z",   OP_REMU, 32'd9, 32'd0, 32'd9, W + 1);
    issue("divu_max", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, W + 1);
    drain();

    // Back-to-back with out_ready held high
    issue("b2b_add", OP_ADD, 32'd3, 32'd4, 32'd7, 1);
    a1 = last_acc;
    issue("b2b_sub", OP_SUB, 32'd10, 32'd3, 32'd7, 1);
    a2 = last_acc;
    issue("b2b_mul", OP_MUL, 32'd3, 32'd5, 32'd15, W + 1);
    a3 = last_acc;
    chk("b2b_interval_1", a2 - a1, 2);
    chk("b2b_interval_2", a3 - a2, 2);
    drain();

    // Backpressure: result must hold, inputs must not be captured
    @(negedge clk);
    out_ready = 1'b0;
    issue("bp_divu", OP_DIVU, 32'd100, 32'd7, 32'd14, W + 1);
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("bp_wait_valid", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_result_hold", result, 32'd14);
      chk("bp_out_valid_hold", out_valid, 1);
      chk("bp_in_ready_low", in_ready, 0);
      in_valid = ~in_valid;
      op = OP_ADD; a = i; b = 32'd1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_consumed", out_valid, 0);
    chk("bp_in_ready_back", in_ready, 1);
    repeat (3) begin
      @(negedge clk);
      chk("bp_no_capture", out_valid, 0);
    end

    // Reset mid-CALC of a mul: nothing from it may ever appear
    @(negedge clk);
    op = OP_MUL; a = 32'd3; b = 32'd4; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("calc_in_ready_low", in_ready, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_in_ready", in_ready, 1);
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_result", result, 0);
    chk("rst2_zero", zero, 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i % 8 == 7) chk("rst2_no_stale", out_valid, 0);
    end
    issue("post_rst_add", OP_ADD, 32'd1, 32'd1, 32'd2, 1);
    drain();

    chk("scoreboard_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
